csi_tx_clk_lane: RTL
====================

CSI_TX_CLK_LANE -- requirements
Module: csi_tx_clk_lane

Interface
REQ-001 SHALL have parameter T_LPX, default 4: LP-01/LP-00 state length, in byte_clock cycles.
REQ-002 SHALL have parameter T_CLK_PREP, default 3: LP-00 to HS-0 preparation, cycles.
REQ-003 SHALL have parameter T_CLK_ZERO, default 20: HS-0 length before toggling, cycles.
REQ-004 SHALL have parameters T_CLK_PRE=2, T_CLK_POST=8, T_CLK_TRAIL=5, T_HS_EXIT=8, all in cycles.
REQ-005 SHALL have port byte_clock  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable  in  1  lane enable; 0 holds the lane in STOP.
REQ-008 SHALL have port hs_req  in  1  data-lane request for a running HS clock.
REQ-009 SHALL have port hs_clk_ready  out  1  clock running and T_CLK_PRE met; data lanes may start HS.
REQ-010 SHALL have port lp_p, lp_n  out  1 each  LP driver levels.
REQ-011 SHALL have port hs_en  out  1  HS driver output enable.
REQ-012 SHALL have port hs_pattern  out  8  OSERDES word: 8'h55 toggling, 8'h00 HS-0.

Function
REQ-013 SHALL implement FSM STOP, HS_RQST, HS_PREP, HS_ZERO, HS_PRE, HS_CLK, HS_POST, HS_TRAIL, HS_EXIT.
REQ-014 SHALL output per state: STOP/HS_EXIT lp=11, hs_en=0; HS_RQST lp=01; HS_PREP lp=00, hs_en=0; HS_ZERO/HS_TRAIL lp=00, hs_en=1, pattern 00; HS_PRE/HS_CLK/HS_POST lp=00, hs_en=1, pattern 55.
REQ-015 SHALL hold each timed state exactly its parameter count of cycles via one 8-bit down-counter loaded on entry; parameter value 0 SHALL behave as 1.
REQ-016 SHALL leave STOP for HS_RQST when enable=1 and hs_req=1, and STOP has lasted at least T_LPX cycles.
REQ-017 SHALL advance RQST->PREP->ZERO->PRE->CLK on counter expiry, unconditionally.
REQ-018 SHALL assert hs_clk_ready registered, exactly while in HS_CLK.
REQ-019 SHALL leave HS_CLK for HS_POST the cycle after hs_req samples 0 or enable samples 0.
REQ-020 SHALL advance POST->TRAIL->EXIT->STOP on expiry; HS_POST keeps toggling for the full T_CLK_POST.
REQ-021 SHALL, when hs_req drops before HS_CLK, finish the start sequence, spend one cycle in HS_CLK with ready=1, then stop; no abort inside HS_ZERO.
REQ-022 SHALL ignore hs_req re-assertion during POST/TRAIL/EXIT; restart only from STOP per REQ-016.
REQ-023 SHALL drive all outputs from registers; no combinational path from inputs to outputs.

Reset
REQ-024 SHALL on reset_n=0 force STOP, lp_p=lp_n=1, hs_en=0, hs_pattern=8'h00, hs_clk_ready=0, counter=0, STOP-age counter=0.
REQ-025 SHALL, after reset deassertion, require T_LPX cycles in STOP before any HS request is honoured.
REQ-026 SHALL, on reset asserted mid-HS, force LP-11 immediately (asynchronously).

Configuration
REQ-027 SHALL support macro CSI_TX_CLK_CONTINUOUS_EN: when defined, HS_CLK is exited only by enable=0 (hs_req low ignored after first entry) and hs_clk_ready equals registered hs_req while in HS_CLK.
REQ-028 SHALL, without CSI_TX_CLK_CONTINUOUS_EN, behave as non-continuous clock per REQ-019.

Structure
REQ-029 SHALL take the state enum and pattern constants (8'h55, 8'h00) from the shared csi_tx package.
REQ-030 SHALL be a single module; no sub-modules.

Verification
REQ-031 SHALL cover a default start: hs_req=1 at STOP age >= 4 -> lp 01 for 4 cycles, 00 for 3, HS-0 for 20, pattern 55 for 2, then ready=1.
REQ-032 SHALL cover stop: hs_req=0 in HS_CLK -> ready=0 next cycle, 8 cycles of 55, 5 cycles of 00, 8 cycles of LP-11, then STOP.
REQ-033 SHALL cover early drop: hs_req pulsed 1 cycle -> full start sequence, one ready cycle, full stop sequence.
REQ-034 SHALL cover reset at HS_ZERO cycle 10 -> lp=11, hs_en=0 same cycle; new hs_req honoured only after 4 cycles.
REQ-035 SHALL cover CSI_TX_CLK_CONTINUOUS_EN: hs_req toggles 1/0 -> stays HS_CLK with ready tracking hs_req; enable=0 -> stop sequence.
REQ-036 SHALL cover T_CLK_ZERO=0 -> HS_ZERO lasts exactly 1 cycle.

Source files
------------

// File: rtl/csi_tx_pkg.sv
// ----------------------------------------------------------------------------
// csi_tx_pkg
// Shared definitions for the CSI-2 transmit lanes.
//   clk_lane_state_e : clock-lane FSM states
//   PatternToggle    : OSERDES word for a toggling HS clock (8'h55)
//   PatternZero      : OSERDES word for HS-0 (8'h00)
//   dwell_load()     : counter load value that holds a state for N cycles
//                      (N = 0 treated as 1)
// ----------------------------------------------------------------------------
package csi_tx_pkg;

    typedef enum logic [3:0] {
        StStop,
        StHsRqst,
        StHsPrep,
        StHsZero,
        StHsPre,
        StHsClk,
        StHsPost,
        StHsTrail,
        StHsExit
    } clk_lane_state_e;

    localparam logic [7:0] PatternToggle = 8'h55;
    localparam logic [7:0] PatternZero   = 8'h00;

    // The dwell counter expires at zero, so N cycles need a load of N-1.
    function automatic logic [7:0] dwell_load(input int unsigned cycles);
        if (cycles == 0) begin
            return 8'd0;
        end
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/csi_tx_clk_lane.sv
// ----------------------------------------------------------------------------
// csi_tx_clk_lane
// MIPI D-PHY clock-lane sequencer: walks the LP-11 -> LP-01 -> LP-00 -> HS-0
// -> HS clock start sequence and the matching stop sequence, all timed in
// byte_clock cycles.
//
// Ports
//   byte_clock    in   sole clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   enable        in   lane enable; 0 keeps the lane in STOP
//   hs_req        in   data-lane request for a running HS clock
//   hs_clk_ready  out  HS clock running, data lanes may start HS
//   lp_p, lp_n    out  LP driver levels
//   hs_en         out  HS driver output enable
//   hs_pattern    out  OSERDES word (8'h55 toggling, 8'h00 HS-0)
//
// Configuration
//   CSI_TX_CLK_CONTINUOUS_EN : when defined, HS_CLK is left only on enable=0
//   and hs_clk_ready follows the registered hs_req while in HS_CLK.
// ----------------------------------------------------------------------------
module csi_tx_clk_lane
    import csi_tx_pkg::*;
#(
    parameter int unsigned T_LPX       = 4,
    parameter int unsigned T_CLK_PREP  = 3,
    parameter int unsigned T_CLK_ZERO  = 20,
    parameter int unsigned T_CLK_PRE   = 2,
    parameter int unsigned T_CLK_POST  = 8,
    parameter int unsigned T_CLK_TRAIL = 5,
    parameter int unsigned T_HS_EXIT   = 8
) (
    input  logic       byte_clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       hs_req,
    output logic       hs_clk_ready,
    output logic       lp_p,
    output logic       lp_n,
    output logic       hs_en,
    output logic [7:0] hs_pattern
);

    // STOP is left on the edge where its age reaches T_LPX-1, giving T_LPX cycles of LP-11.
    localparam logic [7:0] LpxMinAge = dwell_load(T_LPX);

    clk_lane_state_e state_q, state_d;
    logic [7:0]      dwell_q, dwell_d;
    logic [7:0]      stop_age_q, stop_age_d;
    logic            dwell_done;
    logic            clk_exit;
    logic            ready_d;
    logic            lp_p_d, lp_n_d, hs_en_d;
    logic [7:0]      pattern_d;

    assign dwell_done = (dwell_q == 8'd0);

`ifdef CSI_TX_CLK_CONTINUOUS_EN
    assign clk_exit = !enable;
    assign ready_d  = (state_d == StHsClk) && hs_req;
`else
    assign clk_exit = !enable || !hs_req;
    assign ready_d  = (state_d == StHsClk);
`endif

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_done ? 8'd0 : dwell_q - 8'd1;
        unique case (state_q)
            StStop: begin
                dwell_d = 8'd0;
                if (enable && hs_req && (stop_age_q >= LpxMinAge)) begin
                    state_d = StHsRqst;
                    dwell_d = dwell_load(T_LPX);
                end
            end
            StHsRqst: if (dwell_done) begin
                state_d = StHsPrep;
                dwell_d = dwell_load(T_CLK_PREP);
            end
            StHsPrep: if (dwell_done) begin
                state_d = StHsZero;
                dwell_d = dwell_load(T_CLK_ZERO);
            end
            StHsZero: if (dwell_done) begin
                state_d = StHsPre;
                dwell_d = dwell_load(T_CLK_PRE);
            end
            StHsPre: if (dwell_done) begin
                state_d = StHsClk;
                dwell_d = 8'd0;
            end
            StHsClk: begin
                dwell_d = 8'd0;
                if (clk_exit) begin
                    state_d = StHsPost;
                    dwell_d = dwell_load(T_CLK_POST);
                end
            end
            StHsPost: if (dwell_done) begin
                state_d = StHsTrail;
                dwell_d = dwell_load(T_CLK_TRAIL);
            end
            StHsTrail: if (dwell_done) begin
                state_d = StHsExit;
                dwell_d = dwell_load(T_HS_EXIT);
            end
            StHsExit: if (dwell_done) begin
                state_d = StStop;
            end
            default: begin
                state_d = StStop;
                dwell_d = 8'd0;
            end
        endcase

        // Age counts completed STOP cycles; zero on the first STOP cycle.
        if (state_q == StStop) begin
            stop_age_d = (stop_age_q == 8'hff) ? stop_age_q : stop_age_q + 8'd1;
        end else begin
            stop_age_d = 8'd0;
        end
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        lp_p_d    = 1'b0;
        lp_n_d    = 1'b0;
        hs_en_d   = 1'b0;
        pattern_d = PatternZero;
        unique case (state_d)
            StStop, StHsExit: begin
                lp_p_d = 1'b1;
                lp_n_d = 1'b1;
            end
            StHsRqst: lp_n_d = 1'b1;
            StHsPrep: ;
            StHsZero, StHsTrail: hs_en_d = 1'b1;
            StHsPre, StHsClk, StHsPost: begin
                hs_en_d   = 1'b1;
                pattern_d = PatternToggle;
            end
            default: begin
                lp_p_d = 1'b1;
                lp_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StStop;
            dwell_q      <= 8'd0;
            stop_age_q   <= 8'd0;
            lp_p         <= 1'b1;
            lp_n         <= 1'b1;
            hs_en        <= 1'b0;
            hs_pattern   <= PatternZero;
            hs_clk_ready <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            stop_age_q   <= stop_age_d;
            lp_p         <= lp_p_d;
            lp_n         <= lp_n_d;
            hs_en        <= hs_en_d;
            hs_pattern   <= pattern_d;
            hs_clk_ready <= ready_d;
        end
    end

endmodule
